// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
//
// Purpose:
//   Bundles the two buses of the MEM-stage load/store unit. The first is the
//   request/response handshake with the EX/MEM pipeline register. The second
//   is the word-addressed data-memory port.
//
// Modports:
//   slave  - the load/store unit itself.
//            Receives requests and read data.
//            Drives responses and memory enables, address and write data.
//   master - the surroundings of the unit (pipeline plus memory).
//            Drives requests and read data.
//            Observes everything the unit produces.
//
// Signals:
//   req_valid/req_ready                  request handshake
//   req_load/req_store                   access kind
//   req_funct3                           RV32I width/sign selector
//   req_addr                             byte address
//   req_wdata                            store data
//   resp_valid/resp_err                  completion pulse and error flag
//   resp_rdata                           formatted load data
//   mem_r_enable/mem_w_enable            memory enables, sampled by memory on negedge
//   mem_address                          word index
//   mem_wr_data/mem_re_data              memory write and read data
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_re_data;

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_err, resp_rdata,
        output mem_r_enable, mem_w_enable, mem_address, mem_wr_data,
        input  mem_re_data
    );

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_err, resp_rdata,
        input  mem_r_enable, mem_w_enable, mem_address, mem_wr_data,
        output mem_re_data
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//
// Purpose:
//   Load/store unit for the MEM stage of the RV32I pipeline.
//   It is the only client of a word-addressed data memory of DEPTH words.
//   It accepts one load or store at a time and converts the byte address to a
//   word index.
//
//   Loads:
//     Bytes and halfwords are extracted from the memory word.
//     They are then sign- or zero-extended.
//   Stores:
//     Sub-word stores are done as a read-modify-write sequence.
//   Errors:
//     Misaligned, out-of-range or malformed requests are answered with an
//     error response.
//     They never touch memory.
//
// Ports:
//   clk    pipeline clock (the memory samples its enables on the falling edge)
//   rst_n  asynchronous active-low reset
//   bus    lsu_mem_stage_if.slave
//          Carries the request/response handshake and the memory port.
//
// Parameters:
//   DEPTH  number of 32-bit memory words
//   AW     word-index width
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_stage_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD_RESP,
        WRITE,
        RMW_READ,
        RMW_WRITE,
        ERR
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t state;
    state_t state_next;

    logic [AW+1:0] addr_q;
    logic [2:0]    funct3_q;
    logic [31:0]   wdata_q;

    logic          f3_ok;
    logic          misaligned;
    logic          out_of_range;
    logic          req_bad;
    logic          accept;

    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_data;
    logic [31:0]   merged_data;

    assign accept = (state == IDLE) && bus.req_valid;

    // Classify the incoming request.
    // Only the byte and halfword unsigned loads have no store counterpart, so
    // those funct3 codes are accepted for loads only.
    // The halfword/word alignment checks look at funct3[1:0].
    // The unsupported codes that would alias onto these checks are rejected by
    // f3_ok anyway.
    // Anything at or above 4*DEPTH has a nonzero bit above the word index.
    always_comb begin
        f3_ok = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = bus.req_load;
            default:          f3_ok = 1'b0;
        endcase
        misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        out_of_range = |bus.req_addr[31:AW+2];
        req_bad      = (bus.req_load == bus.req_store) || !f3_ok || misaligned || out_of_range;
    end

    // State register and request capture.
    // The captured request only changes on an accept edge. As a result,
    // mem_address and the formatting controls stay frozen for the whole
    // transaction and do not move while idle.
    // Reset drops whatever was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q   <= bus.req_addr[AW+1:0];
                funct3_q <= bus.req_funct3;
                wdata_q  <= bus.req_wdata;
            end
        end
    end

    // Next-state logic.
    // Every non-idle state lasts exactly one cycle. This gives a 1-cycle
    // response for word stores and errors, and a 2-cycle response for loads
    // and sub-word stores.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_bad)
                        state_next = ERR;
                    else if (bus.req_load)
                        state_next = READ;
                    else if (bus.req_funct3 == F3_W)
                        state_next = WRITE;
                    else
                        state_next = RMW_READ;
                end
            end
            READ:      state_next = LOAD_RESP;
            LOAD_RESP: state_next = IDLE;
            WRITE:     state_next = IDLE;
            RMW_READ:  state_next = RMW_WRITE;
            RMW_WRITE: state_next = IDLE;
            ERR:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Lane selection and load formatting from the memory read word.
    //   Byte lane:     chosen by addr[1:0].
    //   Halfword lane: chosen by addr[1].
    // The merged word is the read-modify-write result. The old word has its
    // target lane overwritten with the low bits of the store data.
    always_comb begin
        sel_byte = bus.mem_re_data[7:0];
        case (addr_q[1:0])
            2'd0: sel_byte = bus.mem_re_data[7:0];
            2'd1: sel_byte = bus.mem_re_data[15:8];
            2'd2: sel_byte = bus.mem_re_data[23:16];
            2'd3: sel_byte = bus.mem_re_data[31:24];
            default: sel_byte = bus.mem_re_data[7:0];
        endcase
        sel_half = addr_q[1] ? bus.mem_re_data[31:16] : bus.mem_re_data[15:0];

        load_data = bus.mem_re_data;
        case (funct3_q)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = bus.mem_re_data;
        endcase

        merged_data = bus.mem_re_data;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged_data[7:0]   = wdata_q[7:0];
                2'd1: merged_data[15:8]  = wdata_q[7:0];
                2'd2: merged_data[23:16] = wdata_q[7:0];
                2'd3: merged_data[31:24] = wdata_q[7:0];
                default: merged_data = bus.mem_re_data;
            endcase
        end else if (addr_q[1]) begin
            merged_data[31:16] = wdata_q[15:0];
        end else begin
            merged_data[15:0] = wdata_q[15:0];
        end
    end

    assign bus.mem_address = {{(32-AW){1'b0}}, addr_q[AW+1:2]};

    // Output decode.
    // Everything comes purely from the state plus the captured request.
    // This means reset forces all outputs to their quiet values at once.
    // The read and write enables belong to disjoint states, so they are
    // never high together.
    always_comb begin
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_err     = 1'b0;
        bus.resp_rdata   = 32'd0;
        bus.mem_r_enable = 1'b0;
        bus.mem_w_enable = 1'b0;
        bus.mem_wr_data  = 32'd0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            READ: bus.mem_r_enable = 1'b1;
            LOAD_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = load_data;
            end
            WRITE: begin
                bus.mem_w_enable = 1'b1;
                bus.mem_wr_data  = wdata_q;
                bus.resp_valid   = 1'b1;
            end
            RMW_READ: bus.mem_r_enable = 1'b1;
            RMW_WRITE: begin
                bus.mem_w_enable = 1'b1;
                bus.mem_wr_data  = merged_data;
                bus.resp_valid   = 1'b1;
            end
            ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
            end
            default: bus.req_ready = 1'b0;
        endcase
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the RISC-V pipeline.
- Sits between the EX/MEM pipeline register and the word-addressed 32-word data memory, and is the memory's only client.
- Accepts one RV32I load/store per request and converts byte addresses to word indices.
- Loads: extracts and sign/zero-extends bytes and halfwords. Sub-word stores: performed as a read-modify-write (RMW) sequence. Misaligned or out-of-range accesses: flagged as errors and never reach memory.

Parameters:
DEPTH, 32, number of 32-bit words in the data memory.
AW, 5, word-index width (log2 DEPTH).

Ports:
clk  in  1  pipeline clock; memory samples enables on negedge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit idle, can accept.
req_load  in  1  request is a load.
req_store  in  1  request is a store.
req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
req_addr  in  32  byte address.
req_wdata  in  32  store data (low bits used for SB/SH).
resp_valid  out  1  one-cycle completion pulse.
resp_err  out  1  completion is an error; qualified by resp_valid.
resp_rdata  out  32  formatted load result; 0 unless resp_valid on a successful load.
mem_r_enable  out  1  memory read enable.
mem_w_enable  out  1  memory write enable.
mem_address  out  32  word index; bits [31:AW] always 0.
mem_wr_data  out  32  memory write data.
mem_re_data  in  32  memory read data; valid in the cycle after mem_r_enable.

Behaviour:
- States: IDLE, READ, LOAD_RESP, WRITE, RMW_READ, RMW_WRITE, ERR.
- All memory-side outputs and resp_* are decoded from state plus captured request registers. No output toggles while in IDLE.
- Reset (async, any state): state goes to IDLE. Captured request is cleared. req_ready=1, all other outputs 0. An in-flight transaction is dropped: no write, no response.
- Accept: at a posedge with state IDLE and req_valid=1. Capture load/store, funct3, addr, wdata.
- Transition on accept, error cases (go to ERR):
  - load and store both 0 or both 1
  - unsupported funct3
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - addr >= 4*DEPTH
- Transition on accept, valid cases:
  - LW/LH/LHU/LB/LBU go to READ.
  - SW goes to WRITE.
  - SB/SH go to RMW_READ.
- req_ready=1 only in IDLE. Requests presented in other states are not accepted and must be held by upstream (stall).
- READ: mem_r_enable=1, mem_address=addr[AW+1:2]. Go to LOAD_RESP.
- LOAD_RESP: resp_valid=1. resp_rdata formed from mem_re_data:
  - byte selected by addr[1:0]; halfword selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Go to IDLE.
- WRITE: mem_w_enable=1, mem_wr_data=wdata, resp_valid=1. Go to IDLE.
- RMW_READ: mem_r_enable=1. Go to RMW_WRITE.
- RMW_WRITE: mem_w_enable=1, mem_r_enable=0, resp_valid=1. mem_wr_data = mem_re_data with the target lane replaced:
  - SB: byte addr[1:0] replaced with wdata[7:0].
  - SH: halfword addr[1] replaced with wdata[15:0].
  - Go to IDLE.
- ERR: resp_valid=1, resp_err=1, no memory enables. Go to IDLE.
- Latency from accept edge to resp_valid:
  - SW and errors: 1 cycle.
  - Loads and SB/SH: 2 cycles.
- Throughput: at most one request per latency+1 cycles. Back-to-back requests are accepted on the cycle after the resp_valid cycle.
- mem_r_enable and mem_w_enable are never both 1.
- mem_address is held stable from READ/RMW_READ through the end of the transaction.

Test Plan:
- Memory initialised word i = i. LW addr 0x14 -> READ at cycle 1 with mem_address=5; resp_valid at cycle 2 with resp_rdata=0x00000005, resp_err=0.
- SW 0x80FF7F01 to 0x0C, then in turn:
  - LB 0x0D -> 0x0000007F
  - LB 0x0E -> 0xFFFFFFFF
  - LBU 0x0F -> 0x00000080
  - LH 0x0E -> 0xFFFF80FF
  - LHU 0x0C -> 0x00007F01
- SB 0xAB to 0x11 (word 4 = 4) -> r_enable cycle then w_enable cycle, mem_wr_data=0x0000AB04; a following LW 0x10 returns 0x0000AB04.
- Error cases, each resp_valid+resp_err exactly 1 cycle after accept, with mem_r_enable=mem_w_enable=0 throughout:
  - LW 0x02
  - SH 0x05
  - LW 0x80 (out of range)
  - req_load=req_store=1
- Reset mid-transaction: SH 0xBEEF to 0x08, drop rst_n during RMW_READ -> enables fall immediately, no resp_valid; after release req_ready=1; LW 0x08 returns 0x00000002 (unchanged).
- Stall: req_valid held high with 3 queued LW requests -> req_ready low in READ/LOAD_RESP; accepts land every 3 cycles; responses in order with correct data.
